// File: rtl/controlador_dma_pkg.sv
// Shared definitions for the DMA block-copy controller: FSM state encoding and width defaults.
package pacote_dma;

  localparam int ADDR_W_PADRAO = 26;
  localparam int DATA_W_PADRAO = 32;
  localparam int LEN_W_PADRAO  = 16;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    LER       = 2'd1,
    ESCREVER  = 2'd2,
    CONCLUIDO = 2'd3
  } estado_t;

endpackage

// File: rtl/controlador_dma_contador_endereco.sv
// Loadable word-address register that steps by one and wraps modulo 2^ADDR_W.
module contador_endereco
  import pacote_dma::*;
#(
  parameter int ADDR_W = ADDR_W_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              carregar,
  input  logic              incrementar,
  input  logic [ADDR_W-1:0] inicial,
  output logic [ADDR_W-1:0] valor
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      valor <= '0;
    end else if (carregar) begin
      valor <= inicial;
    end else if (incrementar) begin
      valor <= valor + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/controlador_dma.sv
// DMA controller copying tamanho words from origem to destino, two cycles per word.
// Optional fill mode (one write per cycle with a captured constant) enabled by macro DMA_PREENCHER_EN.
module controlador_dma
  import pacote_dma::*;
#(
  parameter int ADDR_W = ADDR_W_PADRAO,
  parameter int DATA_W = DATA_W_PADRAO,
  parameter int LEN_W  = LEN_W_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] origem,
  input  logic [ADDR_W-1:0] destino,
  input  logic [LEN_W-1:0]  tamanho,
`ifdef DMA_PREENCHER_EN
  input  logic              preencher,
  input  logic [DATA_W-1:0] valor_preencher,
`endif
  output logic              ocupado,
  output logic              concluido,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic              mem_memWrite,
  output logic [DATA_W-1:0] mem_dado_Escrito,
  input  logic [DATA_W-1:0] mem_dado_Lido
);

  estado_t           estado, estado_prox;
  logic [LEN_W-1:0]  contagem;
  logic [DATA_W-1:0] buffer;
  logic [ADDR_W-1:0] src, dst;
  logic              aceitar, ultimo;
  logic              modo_fill, fill_inicio;
  logic [DATA_W-1:0] dado_fill;

  assign aceitar = (estado == OCIOSO) && iniciar;
  assign ultimo  = (contagem == LEN_W'(1));

`ifdef DMA_PREENCHER_EN
  logic              preencher_q;
  logic [DATA_W-1:0] valor_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      preencher_q <= 1'b0;
      valor_q     <= '0;
    end else if (aceitar) begin
      preencher_q <= preencher;
      valor_q     <= valor_preencher;
    end
  end

  assign modo_fill   = preencher_q;
  assign fill_inicio = preencher;
  assign dado_fill   = valor_q;
`else
  assign modo_fill   = 1'b0;
  assign fill_inicio = 1'b0;
  assign dado_fill   = '0;
`endif

  contador_endereco #(.ADDR_W(ADDR_W)) u_src (
    .clock       (clock),
    .reset       (reset),
    .carregar    (aceitar),
    .incrementar (estado == ESCREVER),
    .inicial     (origem),
    .valor       (src)
  );

  contador_endereco #(.ADDR_W(ADDR_W)) u_dst (
    .clock       (clock),
    .reset       (reset),
    .carregar    (aceitar),
    .incrementar (estado == ESCREVER),
    .inicial     (destino),
    .valor       (dst)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= OCIOSO;
      contagem <= '0;
      buffer   <= '0;
    end else begin
      estado <= estado_prox;
      if (aceitar) begin
        contagem <= tamanho;
      end else if (estado == ESCREVER) begin
        contagem <= contagem - LEN_W'(1);
      end
      if (estado == LER) begin
        buffer <= mem_dado_Lido;
      end
    end
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          if (tamanho == '0)    estado_prox = CONCLUIDO;
          else if (fill_inicio) estado_prox = ESCREVER;
          else                  estado_prox = LER;
        end
      end
      LER:      estado_prox = ESCREVER;
      ESCREVER: begin
        if (ultimo)         estado_prox = CONCLUIDO;
        else if (modo_fill) estado_prox = ESCREVER;
        else                estado_prox = LER;
      end
      CONCLUIDO: estado_prox = OCIOSO;
      default:   estado_prox = OCIOSO;
    endcase
  end

  // Write strobe is gated by reset so an aborted in-flight word never lands in memory.
  always_comb begin
    ocupado          = (estado == LER) || (estado == ESCREVER);
    concluido        = (estado == CONCLUIDO);
    mem_endereco     = '0;
    mem_memWrite     = 1'b0;
    mem_dado_Escrito = '0;
    case (estado)
      LER: mem_endereco = src;
      ESCREVER: begin
        mem_endereco     = dst;
        mem_memWrite     = reset;
        mem_dado_Escrito = modo_fill ? dado_fill : buffer;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controlador_dma.sv
// Directed bench for controlador_dma: a bus scoreboard checks every read/write against queued expectations.
module tb_controlador_dma;
  import pacote_dma::*;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } evento_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              iniciar;
  logic [ADDR_W-1:0] origem, destino;
  logic [LEN_W-1:0]  tamanho;
  logic              ocupado, concluido, mem_memWrite;
  logic [ADDR_W-1:0] mem_endereco;
  logic [DATA_W-1:0] mem_dado_Escrito, mem_dado_Lido;
`ifdef DMA_PREENCHER_EN
  logic              preencher;
  logic [DATA_W-1:0] valor_preencher;
`endif

  logic [DATA_W-1:0] mem [0:255];
  logic              pre_we = 1'b0;
  logic [7:0]        pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  evento_t esperado[$];
  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  controlador_dma dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .origem           (origem),
    .destino          (destino),
    .tamanho          (tamanho),
`ifdef DMA_PREENCHER_EN
    .preencher        (preencher),
    .valor_preencher  (valor_preencher),
`endif
    .ocupado          (ocupado),
    .concluido        (concluido),
    .mem_endereco     (mem_endereco),
    .mem_memWrite     (mem_memWrite),
    .mem_dado_Escrito (mem_dado_Escrito),
    .mem_dado_Lido    (mem_dado_Lido)
  );

  // Small memory model aliased on the low 8 address bits; combinational read.
  assign mem_dado_Lido = mem[mem_endereco[7:0]];

  always @(posedge clock) begin
    if (mem_memWrite === 1'b1) mem[mem_endereco[7:0]] <= mem_dado_Escrito;
    else if (pre_we)           mem[pre_addr] <= pre_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: every access while busy must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset === 1'b1 && ocupado === 1'b1) begin
      chk("bus_access_expected", 64'(esperado.size() > 0), 64'd1);
      if (esperado.size() > 0) begin
        evento_t ev;
        ev = esperado.pop_front();
        chk("bus_kind", 64'(mem_memWrite), 64'(ev.wr));
        chk("bus_addr", 64'(mem_endereco), 64'(ev.addr));
        if (ev.wr) chk("bus_wdata", 64'(mem_dado_Escrito), 64'(ev.data));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [DATA_W-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic push(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    evento_t ev;
    ev.wr = wr; ev.addr = a; ev.data = d;
    esperado.push_back(ev);
  endtask

  task automatic start(input logic [ADDR_W-1:0] o, input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] n);
    origem = o; destino = d; tamanho = n; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    origem  = ADDR_W'($urandom);
    destino = ADDR_W'($urandom);
    tamanho = LEN_W'($urandom);
  endtask

  initial begin
    logic [DATA_W-1:0] pal [4];
    pal[0] = 32'hA0A0_0001; pal[1] = 32'hB0B0_0002;
    pal[2] = 32'hC0C0_0003; pal[3] = 32'hD0D0_0004;

    reset = 1'b0; iniciar = 1'b1; origem = '0; destino = '0; tamanho = 16'd4;
`ifdef DMA_PREENCHER_EN
    preencher = 1'b0; valor_preencher = '0;
`endif
    tick(); tick();
    chk("rst_ocupado",   64'(ocupado), 64'd0);
    chk("rst_concluido", 64'(concluido), 64'd0);
    chk("rst_memWrite",  64'(mem_memWrite), 64'd0);
    chk("rst_endereco",  64'(mem_endereco), 64'd0);
    chk("rst_dado",      64'(mem_dado_Escrito), 64'd0);
    iniciar = 1'b0; reset = 1'b1;
    tick();
    chk("post_rst_idle", 64'(ocupado), 64'd0);

    // Basic copy 10..13 -> 30..33
    for (int i = 0; i < 4; i++) preload(8'(10 + i), pal[i]);
    for (int i = 0; i < 4; i++) begin
      push(1'b0, ADDR_W'(10 + i), '0);
      push(1'b1, ADDR_W'(30 + i), pal[i]);
    end
    start(26'd10, 26'd30, 16'd4);
    for (int c = 1; c <= 8; c++) begin
      chk("copy_ocupado",   64'(ocupado), 64'd1);
      chk("copy_concluido", 64'(concluido), 64'd0);
      tick();
    end
    chk("copy_done_pulse", 64'(concluido), 64'd1);
    chk("copy_done_idle",  64'(ocupado), 64'd0);
    tick();
    chk("copy_done_once",  64'(concluido), 64'd0);
    chk("copy_idle_addr",  64'(mem_endereco), 64'd0);
    for (int i = 0; i < 4; i++) chk("copy_mem", 64'(mem[30 + i]), 64'(pal[i]));
    chk("copy_queue_empty", 64'(esperado.size()), 64'd0);

    // Zero length
    start(26'd10, 26'd30, 16'd0);
    chk("zero_concluido", 64'(concluido), 64'd1);
    chk("zero_ocupado",   64'(ocupado), 64'd0);
    chk("zero_memWrite",  64'(mem_memWrite), 64'd0);
    tick();
    chk("zero_done_once", 64'(concluido), 64'd0);
    chk("zero_ocupado2",  64'(ocupado), 64'd0);

    // Address wrap at the top of the space
    preload(8'hFE, 32'h1111_0001);
    preload(8'hFF, 32'h2222_0002);
    preload(8'h00, 32'h3333_0003);
    push(1'b0, 26'h3FFFFFE, '0); push(1'b1, 26'd5, 32'h1111_0001);
    push(1'b0, 26'h3FFFFFF, '0); push(1'b1, 26'd6, 32'h2222_0002);
    push(1'b0, 26'h0000000, '0); push(1'b1, 26'd7, 32'h3333_0003);
    start(26'h3FFFFFE, 26'd5, 16'd3);
    repeat (6) tick();
    chk("wrap_concluido", 64'(concluido), 64'd1);
    tick();
    chk("wrap_mem7", 64'(mem[7]), 64'h3333_0003);
    chk("wrap_queue_empty", 64'(esperado.size()), 64'd0);

    // Busy restart ignored, then reset during the second word's write
    preload(8'd40, 32'h4040_0001);
    preload(8'd41, 32'h4040_0002);
    preload(8'd50, 32'h5050_5050);
    preload(8'd51, 32'h5151_5151);
    preload(8'd60, 32'h6060_6060);
    push(1'b0, 26'd40, '0); push(1'b1, 26'd50, 32'h4040_0001);
    push(1'b0, 26'd41, '0);
    start(26'd40, 26'd50, 16'd4);
    tick(); tick();
    origem = 26'd0; destino = 26'd60; tamanho = 16'd1; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("abort_in_write",  64'(mem_memWrite), 64'd1);
    chk("abort_write_dst", 64'(mem_endereco), 64'd51);
    reset = 1'b0;
    #1;
    chk("abort_write_gated", 64'(mem_memWrite), 64'd0);
    tick();
    chk("abort_ocupado", 64'(ocupado), 64'd0);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("abort_no_concluido", 64'(concluido), 64'd0);
      tick();
    end
    chk("abort_mem50", 64'(mem[50]), 64'h4040_0001);
    chk("abort_mem51", 64'(mem[51]), 64'h5151_5151);
    chk("abort_mem60", 64'(mem[60]), 64'h6060_6060);
    chk("abort_queue_empty", 64'(esperado.size()), 64'd0);
    esperado.delete();

`ifdef DMA_PREENCHER_EN
    // Fill mode: one write per cycle, no reads
    for (int i = 0; i < 3; i++) push(1'b1, ADDR_W'(20 + i), 32'hDEADBEEF);
    preencher = 1'b1; valor_preencher = 32'hDEADBEEF;
    start(26'd3, 26'd20, 16'd3);
    preencher = 1'b0; valor_preencher = '0;
    for (int c = 1; c <= 3; c++) begin
      chk("fill_write_each_cycle", 64'(mem_memWrite), 64'd1);
      tick();
    end
    chk("fill_concluido", 64'(concluido), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) chk("fill_mem", 64'(mem[20 + i]), 64'hDEADBEEF);
    chk("fill_queue_empty", 64'(esperado.size()), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
